// File: rtl/score_display_pkg.sv
// Shared display constants, status encodings and conversion helpers for the
// score overlay.
package score_display_pkg;

  localparam int unsigned GLYPH_W      = 8;
  localparam int unsigned GLYPH_W_LOG2 = 3;
  localparam int unsigned GLYPH_H      = 16;
  localparam int unsigned SCORE_W      = 10;
  localparam int unsigned BCD_W        = 12;
  localparam logic [3:0]  BLANK        = 4'd10;

  typedef enum logic [1:0] {
    STATUS_RESTART,
    STATUS_START,
    STATUS_PLAY,
    STATUS_DIE
  } game_status_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD
  } conv_state_e;

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s,
                                                   input logic [SCORE_W-1:0] m);
    return (s > m) ? m : s;
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Score overlay port bundle: game score and scan position in, pixel and digits out.
interface score_display_if;
  import score_display_pkg::*;

  logic [SCORE_W-1:0] score;
  logic [9:0]         posx;
  logic [9:0]         posy;
  logic               score_char;
  logic [BCD_W-1:0]   bcd;
  logic               busy;

  modport master (
    output score, posx, posy,
    input  score_char, bcd, busy
  );

  modport slave (
    input  score, posx, posy,
    output score_char, bcd, busy
  );
endinterface

// File: rtl/score_display_digit_font_rom.sv
// Combinational 8x16 digit font: codes 0-9 are digits, 10-15 are blank.
module digit_font_rom
  import score_display_pkg::*;
(
  input  logic [3:0] code,
  input  logic [3:0] row,
  output logic [7:0] bits
);

  logic [127:0] glyph_c;

  // Row 0 is the most significant byte; bit 7 of each byte is the leftmost pixel.
  always_comb begin
    glyph_c = '0;
    case (code)
      4'd0: glyph_c = 128'h0000_3C66_666E_7666_6666_6666_3C00_0000;
      4'd1: glyph_c = 128'h0000_1838_7818_1818_1818_1818_7E00_0000;
      4'd2: glyph_c = 128'h0000_3C66_0606_0C18_3060_6066_7E00_0000;
      4'd3: glyph_c = 128'h0000_3C66_0606_1C06_0606_0666_3C00_0000;
      4'd4: glyph_c = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C0C_1E00_0000;
      4'd5: glyph_c = 128'h0000_7E60_6060_7C06_0606_0666_3C00_0000;
      4'd6: glyph_c = 128'h0000_1C30_6060_7C66_6666_6666_3C00_0000;
      4'd7: glyph_c = 128'h0000_7E66_0606_0C18_3030_3030_3000_0000;
      4'd8: glyph_c = 128'h0000_3C66_6666_3C66_6666_6666_3C00_0000;
      4'd9: glyph_c = 128'h0000_3C66_6666_663E_0606_060C_3800_0000;
      default: glyph_c = '0;
    endcase
    bits = glyph_c[{~row, 3'b000} +: 8];
  end

endmodule

// File: rtl/score_display.sv
// Score overlay: per-frame binary-to-BCD conversion plus a 1-cycle pixel
// pipeline that lights glyph bits of the displayed digits.
module score_display
  import score_display_pkg::*;
#(
  parameter logic [9:0]  X0        = 10'd16,
  parameter logic [9:0]  Y0        = 10'd8,
  parameter int unsigned SCALE_SH  = 1,
  parameter logic [9:0]  MAX_SCORE = 10'd999
) (
  input  logic     clk25,
  input  logic     rst,
  score_display_if.slave dif
);

  localparam int unsigned DIGIT_W = GLYPH_W << SCALE_SH;
  localparam int unsigned DIGIT_H = GLYPH_H << SCALE_SH;
  localparam int unsigned DIG_SH  = GLYPH_W_LOG2 + SCALE_SH;
  localparam logic [9:0]  X_END   = 10'(32'(X0) + 3 * DIGIT_W);
  localparam logic [9:0]  Y_END   = 10'(32'(Y0) + DIGIT_H);
  localparam int unsigned WORK_W  = BCD_W + SCORE_W;

  conv_state_e        state_q;
  logic [3:0]         cnt_q;
  logic [WORK_W-1:0]  work_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               busy_q;
  logic               origin_q;
  logic               score_char_q;

  logic               origin_c;
  logic               frame_start_c;
  logic [BCD_W-1:0]   adj_c;
  logic               in_field_c;
  logic [9:0]         rx_c;
  logic [9:0]         ry_c;
  logic [1:0]         digit_c;
  logic [2:0]         col_c;
  logic [3:0]         row_c;
  logic [3:0]         code_c;
  logic [7:0]         font_bits_c;
  logic               pix_c;

  assign dif.score_char = score_char_q;
  assign dif.bcd        = bcd_q;
  assign dif.busy       = busy_q;

  // Frame start is the rising edge of the (0,0) scan position.
  always_comb begin
    origin_c      = (dif.posx == 10'd0) && (dif.posy == 10'd0);
    frame_start_c = origin_c && !origin_q;
    adj_c         = dd_adjust(work_q[WORK_W-1:SCORE_W]);
  end

  // Field geometry and digit selection with leading-zero blanking.
  always_comb begin
    in_field_c = (dif.posx >= X0) && (dif.posx < X_END) &&
                 (dif.posy >= Y0) && (dif.posy < Y_END);
    rx_c       = dif.posx - X0;
    ry_c       = dif.posy - Y0;
    digit_c    = 2'(rx_c >> DIG_SH);
    col_c      = 3'(rx_c >> SCALE_SH);
    row_c      = 4'(ry_c >> SCALE_SH);
    code_c     = bcd_q[3:0];
    case (digit_c)
      2'd0:    code_c = (bcd_q[11:8] == 4'd0) ? BLANK : bcd_q[11:8];
      2'd1:    code_c = (bcd_q[11:4] == 8'd0) ? BLANK : bcd_q[7:4];
      default: code_c = bcd_q[3:0];
    endcase
  end

  digit_font_rom u_font (
    .code (code_c),
    .row  (row_c),
    .bits (font_bits_c)
  );

  assign pix_c = in_field_c && font_bits_c[~col_c];

  // Conversion FSM and registered pixel output.
  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      work_q       <= '0;
      bcd_q        <= '0;
      busy_q       <= 1'b0;
      origin_q     <= 1'b0;
      score_char_q <= 1'b0;
    end else begin
      origin_q     <= origin_c;
      score_char_q <= pix_c;
      case (state_q)
        ST_IDLE: begin
          if (frame_start_c) begin
            work_q  <= {BCD_W'(0), sat_score(dif.score, MAX_SCORE)};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work_q <= {adj_c[BCD_W-2:0], work_q[SCORE_W-1:0], 1'b0};
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'(SCORE_W - 1)) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          bcd_q   <= work_q[WORK_W-1:SCORE_W];
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: conversion timing, saturation, blanking,
// mid-frame score changes, reset abort and pixel-level glyph rendering.
module tb_score_display;

  logic clk25;
  logic rst;
  int   vectors;
  int   miscompares;

  score_display_if dif ();

  score_display dut (
    .clk25 (clk25),
    .rst   (rst),
    .dif   (dif.slave)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  // Hand-entered font: rows 0..15 per digit, bit 7 leftmost.
  logic [7:0] font [10][16] = '{
    '{8'h00,8'h00,8'h3C,8'h66,8'h66,8'h6E,8'h76,8'h66,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h18,8'h38,8'h78,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h7E,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h3C,8'h66,8'h06,8'h06,8'h0C,8'h18,8'h30,8'h60,8'h60,8'h66,8'h7E,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h3C,8'h66,8'h06,8'h06,8'h1C,8'h06,8'h06,8'h06,8'h06,8'h66,8'h3C,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h0C,8'h1C,8'h3C,8'h6C,8'hCC,8'hFE,8'h0C,8'h0C,8'h0C,8'h0C,8'h1E,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h7E,8'h60,8'h60,8'h60,8'h7C,8'h06,8'h06,8'h06,8'h06,8'h66,8'h3C,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h1C,8'h30,8'h60,8'h60,8'h7C,8'h66,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h7E,8'h66,8'h06,8'h06,8'h0C,8'h18,8'h30,8'h30,8'h30,8'h30,8'h30,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h3C,8'h66,8'h66,8'h66,8'h3C,8'h66,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h3C,8'h66,8'h66,8'h66,8'h66,8'h3E,8'h06,8'h06,8'h06,8'h0C,8'h38,8'h00,8'h00,8'h00}
  };

  // Field at x 16..63, y 8..39; each digit 16x32 with 2x2 pixel blocks.
  function automatic logic exp_pix(input int x, input int y,
                                   input logic [3:0] h, input logic [3:0] t,
                                   input logic [3:0] o);
    int rx, ry, d, col, row;
    logic [3:0] code;
    logic [7:0] b;
    if (x < 16 || x >= 64 || y < 8 || y >= 40) return 1'b0;
    rx   = x - 16;
    ry   = y - 8;
    d    = rx / 16;
    col  = (rx % 16) / 2;
    row  = ry / 2;
    if (d == 0 && h == 4'd0) return 1'b0;
    if (d == 1 && h == 4'd0 && t == 4'd0) return 1'b0;
    code = (d == 0) ? h : ((d == 1) ? t : o);
    b    = font[code][row];
    return b[7 - col];
  endfunction

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic park();
    dif.posx = 10'd700;
    dif.posy = 10'd500;
  endtask

  // One frame start; busy must cover SHIFT+LOAD and bcd change only after LOAD.
  task automatic run_frame(input logic [9:0] s, input logic [11:0] prev,
                           input logic [11:0] exp, input string tag);
    int busy_cnt;
    dif.score = s;
    @(negedge clk25);
    dif.posx = 10'd0;
    dif.posy = 10'd0;
    busy_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk25);
      #1;
      if (i == 0) park();
      if (dif.busy === 1'b1) busy_cnt++;
    end
    check(32'(busy_cnt), 32'd11, {tag, "_busy_cycles"});
    check(32'(dif.bcd), 32'(prev), {tag, "_bcd_before_load"});
    @(posedge clk25);
    #1;
    check(32'(dif.busy), 32'd0, {tag, "_busy_done"});
    check(32'(dif.bcd), 32'(exp), {tag, "_bcd"});
  endtask

  task automatic scan(input logic [11:0] digits, input string tag);
    for (int y = 1; y < 48; y++) begin
      for (int x = 0; x < 80; x++) begin
        @(negedge clk25);
        dif.posx = 10'(x);
        dif.posy = 10'(y);
        @(posedge clk25);
        #1;
        check(32'(dif.score_char),
              32'(exp_pix(x, y, digits[11:8], digits[7:4], digits[3:0])),
              $sformatf("%s_px_%0d_%0d", tag, x, y));
      end
    end
    @(negedge clk25);
    park();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    dif.score   = 10'd0;
    park();

    // Reset for 3 cycles, no frame start.
    repeat (3) @(posedge clk25);
    #1;
    rst = 1'b0;
    check(32'(dif.bcd), 32'h000, "reset_bcd");
    check(32'(dif.busy), 32'd0, "reset_busy");
    check(32'(dif.score_char), 32'd0, "reset_score_char");
    scan(12'h000, "scan000");

    run_frame(10'd345, 12'h000, 12'h345, "s345");
    scan(12'h345, "scan345");

    run_frame(10'd7, 12'h345, 12'h007, "s7");
    scan(12'h007, "scan007");

    run_frame(10'd1023, 12'h007, 12'h999, "sat1023");
    run_frame(10'd100, 12'h999, 12'h100, "s100");
    scan(12'h100, "scan100");

    // Score change mid-frame must wait for the next frame start.
    run_frame(10'd123, 12'h100, 12'h123, "s123");
    @(negedge clk25);
    dif.posx  = 10'd100;
    dif.posy  = 10'd200;
    dif.score = 10'd456;
    repeat (20) @(posedge clk25);
    #1;
    check(32'(dif.bcd), 32'h123, "midframe_hold_bcd");
    check(32'(dif.busy), 32'd0, "midframe_busy");
    park();
    run_frame(10'd456, 12'h123, 12'h456, "s456");

    // Reset during the 5th SHIFT cycle of converting 999.
    dif.score = 10'd999;
    @(negedge clk25);
    dif.posx = 10'd0;
    dif.posy = 10'd0;
    @(posedge clk25);
    #1;
    park();
    check(32'(dif.busy), 32'd1, "abort_busy_start");
    repeat (4) @(posedge clk25);
    #1;
    rst = 1'b1;
    @(posedge clk25);
    #1;
    rst = 1'b0;
    check(32'(dif.bcd), 32'h000, "abort_bcd");
    check(32'(dif.busy), 32'd0, "abort_busy");
    repeat (15) @(posedge clk25);
    #1;
    check(32'(dif.bcd), 32'h000, "abort_no_partial_load");
    run_frame(10'd999, 12'h000, 12'h999, "s999_after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
